// File: rtl/alu_sched.sv
// alu_sched: two-requester round-robin scheduler for one shared, external,
// combinational 16-bit ALU. One operation is in flight at a time:
// IDLE (grant) -> EXEC (capture ALU result) -> RESP (hold until acked).
// Optional feature: define ALU_SCHED_OFL_CNT_EN to build a saturating
// overflow event counter on ofl_cnt; otherwise ofl_cnt is tied to zero.
module alu_sched #(
  parameter int PRIO_INIT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_vld,
  output logic [1:0]  req_rdy,
  input  logic [31:0] req_A,
  input  logic [31:0] req_B,
  input  logic [5:0]  req_op,
  input  logic [7:0]  req_ctl,
  output logic [1:0]  rsp_vld,
  input  logic [1:0]  rsp_ack,
  output logic [15:0] rsp_out,
  output logic        rsp_ofl,
  output logic        rsp_z,
  output logic [15:0] alu_A,
  output logic [15:0] alu_B,
  output logic [2:0]  alu_Op,
  output logic        alu_Cin,
  output logic        alu_invA,
  output logic        alu_invB,
  output logic        alu_sign,
  input  logic [15:0] alu_Out,
  input  logic        alu_Ofl,
  input  logic        alu_Z,
  output logic [15:0] ofl_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic       PTR_RST = (PRIO_INIT != 0);

  logic [1:0] r_state;
  logic       r_ptr;
  logic       r_gnt;

  logic [15:0] w_req_A   [2];
  logic [15:0] w_req_B   [2];
  logic [2:0]  w_req_op  [2];
  logic [3:0]  w_req_ctl [2];
  logic        w_pick;
  logic        w_xfer;

  // Unpack the per-requester operand fields from the packed buses.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_unpack
      assign w_req_A[gi]   = req_A[16*gi +: 16];
      assign w_req_B[gi]   = req_B[16*gi +: 16];
      assign w_req_op[gi]  = req_op[3*gi +: 3];
      assign w_req_ctl[gi] = req_ctl[4*gi +: 4];
    end
  endgenerate

  // The pointer's requester wins if it asks; otherwise the other one may go.
  assign w_pick  = req_vld[r_ptr] ? r_ptr : ~r_ptr;
  assign w_xfer  = (r_state == IDLE) && (|req_vld);
  assign req_rdy = w_xfer ? (w_pick ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_vld = (r_state == RESP) ? (r_gnt ? 2'b10 : 2'b01) : 2'b00;

  // Sequencing: grant in IDLE, single EXEC cycle, wait for ack in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= PTR_RST;
      r_gnt   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_xfer) begin
          r_state <= EXEC;
          r_gnt   <= w_pick;
        end
        EXEC: r_state <= RESP;
        RESP: if (rsp_ack[r_gnt]) begin
          r_state <= IDLE;
          r_ptr   <= ~r_gnt;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Load the granted requester's operands onto the shared ALU on transfer;
  // they stay put until the next transfer so the result remains stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_A    <= '0;
      alu_B    <= '0;
      alu_Op   <= '0;
      alu_Cin  <= 1'b0;
      alu_invA <= 1'b0;
      alu_invB <= 1'b0;
      alu_sign <= 1'b0;
    end else if (w_xfer) begin
      alu_A    <= w_req_A[w_pick];
      alu_B    <= w_req_B[w_pick];
      alu_Op   <= w_req_op[w_pick];
      alu_Cin  <= w_req_ctl[w_pick][0];
      alu_invA <= w_req_ctl[w_pick][1];
      alu_invB <= w_req_ctl[w_pick][2];
      alu_sign <= w_req_ctl[w_pick][3];
    end
  end

  // Capture the ALU result during the EXEC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_out <= '0;
      rsp_ofl <= 1'b0;
      rsp_z   <= 1'b0;
    end else if (r_state == EXEC) begin
      rsp_out <= alu_Out;
      rsp_ofl <= alu_Ofl;
      rsp_z   <= alu_Z;
    end
  end

`ifdef ALU_SCHED_OFL_CNT_EN
  logic [15:0] r_ofl_cnt;

  // Count overflowing operations, holding at the maximum instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ofl_cnt <= '0;
    end else if ((r_state == EXEC) && alu_Ofl && (r_ofl_cnt != 16'hFFFF)) begin
      r_ofl_cnt <= r_ofl_cnt + 16'd1;
    end
  end

  assign ofl_cnt = r_ofl_cnt;
`else
  assign ofl_cnt = 16'h0000;
`endif

endmodule
